// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: third-order CIC (sinc3) decimator turning a 1-bit PDM
// stream into signed W-bit PCM samples, delivered on a valid/ready output
// with a sticky overrun flag when an unconsumed sample is overwritten.
module pdm_cic_decimator #(
    parameter int W     = 16,
    parameter int DECIM = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         in,
    output logic [W-1:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         overrun
);

    localparam int L     = $clog2(DECIM);
    localparam int B     = 3 * L + 2;
    localparam int SHIFT = 3 * L - (W - 1);

    localparam logic signed [B-1:0] S_MAX = B'(2 ** (W - 1) - 1);
    localparam logic signed [B-1:0] S_MIN = ~S_MAX;

    // Scale the comb output down to W bits (arithmetic, truncating) and clip;
    // only the full-scale positive result +R^3 lands outside the W-bit range.
    function automatic logic signed [W-1:0] scale_sat(input logic signed [B-1:0] y);
        logic signed [B-1:0] s;
        s = y >>> SHIFT;
        if (s > S_MAX)
            return S_MAX[W-1:0];
        else if (s < S_MIN)
            return S_MIN[W-1:0];
        else
            return s[W-1:0];
    endfunction

    logic signed [B-1:0] x;
    logic signed [B-1:0] i1, i2, i3;
    logic        [L-1:0] cnt;
    logic                dec_evt;

    logic signed [B-1:0] c0_p0, c1_p1, c2_p2, c3_p3;
    logic signed [B-1:0] d0, d1, d2;
    logic                vld_p0, vld_p1, vld_p2, vld_p3;
    logic        [1:0]   warm;

    // PDM bit mapped to +1 / -1 in B-bit two's complement.
    assign x       = {{(B-1){~in}}, 1'b1};
    assign dec_evt = clk_en && (cnt == L'(DECIM - 1));

    // Integrator chain at the PDM rate; each stage adds the previous-cycle
    // value of the stage before it, wrapping modulo 2^B.
    always_ff @(posedge clk) begin
        if (rst) begin
            i1  <= '0;
            i2  <= '0;
            i3  <= '0;
            cnt <= '0;
        end else if (clk_en) begin
            i1  <= i1 + x;
            i2  <= i2 + i1;
            i3  <= i3 + i2;
            cnt <= cnt + 1'b1;
        end
    end

    // Comb chain at the decimated rate: each stage advances only when a
    // result reaches it, so the delays hold the previous decimated value.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
            c0_p0  <= '0;
            c1_p1  <= '0;
            c2_p2  <= '0;
            c3_p3  <= '0;
            d0     <= '0;
            d1     <= '0;
            d2     <= '0;
        end else begin
            // p0: capture the last integrator on the decimation event
            vld_p0 <= dec_evt;
            if (dec_evt)
                c0_p0 <= i3;
            // p1: first comb
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                c1_p1 <= c0_p0 - d0;
                d0    <= c0_p0;
            end
            // p2: second comb
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                c2_p2 <= c1_p1 - d1;
                d1    <= c1_p1;
            end
            // p3: third comb
            vld_p3 <= vld_p2;
            if (vld_p2) begin
                c3_p3 <= c2_p2 - d2;
                d2    <= c2_p2;
            end
        end
    end

    // Output register: drop the first three results while the comb history
    // fills, then present samples; a new sample always replaces the old one.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            warm      <= '0;
        end else if (vld_p3 && (warm != 2'd3)) begin
            warm <= warm + 2'd1;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
        end else if (vld_p3) begin
            out       <= scale_sat(c3_p3);
            out_valid <= 1'b1;
            if (out_valid && !out_ready)
                overrun <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb_pdm_cic_decimator: randomized and patterned PDM stimulus; expected PCM
// samples come from a direct sinc3 convolution of the applied bit history.
module tb_pdm_cic_decimator;

    localparam int W     = 16;
    localparam int R     = 64;
    localparam int L     = 6;
    localparam int SHIFT = 3 * L - (W - 1);
    localparam int HLEN  = 3 * R - 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         clk_en;
    logic         in_bit;
    logic [W-1:0] out;
    logic         out_valid;
    logic         out_ready;
    logic         overrun;

    pdm_cic_decimator #(.W(W), .DECIM(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .in        (in_bit),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int edge_n;
    } exp_t;

    exp_t exp_q[$];
    int   x_hist[$];
    int   h[HLEN];
    int   h2[2*R-1];
    int   pulses = 0;
    int   warm   = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_acc  = 0;
    int   last_acc = 0;
    bit   rdy_rand = 1'b0;
    bit   rdy_fix  = 1'b1;
    bit   prev_v   = 1'b0;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic check_near(input string nm, input int act, input int req, input int tol);
        n_cmp++;
        if (act < req - tol || act > req + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +-%0d", nm, act, req, tol);
        end
    endtask

    function automatic int pcm_of(input int y);
        int s;
        s = y >>> SHIFT;
        if (s > (1 << (W - 1)) - 1) s = (1 << (W - 1)) - 1;
        if (s < -(1 << (W - 1)))    s = -(1 << (W - 1));
        return s;
    endfunction

    // Decimated output n (at pulse count p = n*R) is the sinc3 impulse
    // response convolved with the bit history, aligned three pulses back.
    task automatic model_event(input int edge_n);
        int   y;
        int   k;
        exp_t e;
        y = 0;
        for (int j = 0; j < HLEN; j++) begin
            k = pulses - 3 - j;
            if (k >= 1) y += h[j] * x_hist[k-1];
        end
        if (warm < 3) begin
            warm++;
        end else begin
            e.val    = pcm_of(y);
            e.edge_n = edge_n;
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse(input bit en, input bit b);
        @(posedge clk);
        #1;
        clk_en    = en;
        in_bit    = b;
        out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fix;
        if (en) begin
            x_hist.push_back(b ? 1 : -1);
            pulses++;
            if (pulses % R == 0) model_event(cyc + 1);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst    = 1'b1;
        clk_en = 1'b0;
        exp_q.delete();
        x_hist.delete();
        pulses = 0;
        warm   = 0;
        @(posedge clk);
        @(negedge clk);
        check("rst_out", int'($signed(out)), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_overrun", int'(overrun), 0);
        rst = 1'b0;
    endtask

    function automatic bit pat_bit(input int kind, input int k);
        case (kind)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (k % 2) == 0;
            3:       return (k % 4) != 3;
            4:       return (k % 4) == 0;
            default: return 1'(($urandom & 1));
        endcase
    endfunction

    task automatic run_pattern(input int kind, input int npulse, input int en_period);
        for (int k = 0; k < npulse; k++) begin
            for (int s = 1; s < en_period; s++) pulse(1'b0, 1'b0);
            pulse(1'b1, pat_bit(kind, k));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) pulse(1'b0, 1'b0);
    endtask

    // Monitor: compares every accepted sample with the oldest expected one
    // and checks that a fresh sample appears 4 clocks after its event.
    always @(negedge clk) begin
        int   v;
        exp_t e;
        if (!rst) begin
            v = int'($signed(out));
            if (out_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_sample: got %0d, expected no sample", v);
                end else begin
                    check("latency", cyc, exp_q[0].edge_n + 4);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL accept_empty: got %0d, expected no sample", v);
                end else begin
                    e = exp_q.pop_front();
                    check("sample", v, e.val);
                end
                last_acc = v;
                n_acc++;
            end
        end
        prev_v = out_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst       = 1'b1;
        clk_en    = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < R; j++) h2[i+j] += 1;
        for (int a = 0; a < 2*R-1; a++)
            for (int b = 0; b < R; b++) h[a+b] += h2[a];
        repeat (2) @(posedge clk);
        do_reset();

        // Constant 1 after reset: three results dropped, then full scale.
        base = n_acc;
        run_pattern(0, 6*R, 1);
        idle(8);
        check("const1_count", n_acc - base, 3);
        check("const1_value", last_acc, 32767);

        run_pattern(1, 6*R, 1);
        idle(8);
        check("const0_value", last_acc, -32768);
        check("const0_overrun", int'(overrun), 0);

        run_pattern(2, 6*R, 1);
        idle(8);
        check("alt_value", last_acc, 0);

        run_pattern(3, 6*R, 1);
        idle(8);
        check_near("p1110_value", last_acc, 16384, 1);

        run_pattern(4, 6*R, 1);
        idle(8);
        check_near("p1000_value", last_acc, -16384, 1);

        // Random bits with a randomly stalling consumer.
        rdy_rand = 1'b1;
        run_pattern(5, 8*R, 1);
        rdy_rand = 1'b0;
        rdy_fix  = 1'b1;
        idle(8);
        check("rand_overrun", int'(overrun), 0);

        // Consumer stalled across two results: the newer sample wins.
        rdy_fix = 1'b0;
        run_pattern(5, 2*R, 1);
        idle(8);
        while (exp_q.size() > 1) void'(exp_q.pop_front());
        @(negedge clk);
        check("ovr_flag", int'(overrun), 1);
        check("ovr_valid", int'(out_valid), 1);
        rdy_fix = 1'b1;
        pulse(1'b0, 1'b0);
        pulse(1'b0, 1'b0);
        @(negedge clk);
        check("ovr_valid_cleared", int'(out_valid), 0);
        check("ovr_sticky", int'(overrun), 1);

        // clk_en once every four clocks.
        run_pattern(5, 4*R, 4);
        idle(8);

        // Reset mid-stream, then only the 4th result is delivered.
        run_pattern(5, 100, 1);
        do_reset();
        base = n_acc;
        run_pattern(5, 4*R, 1);
        idle(8);
        check("post_rst_count", n_acc - base, 1);

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
